// File: rtl/apb_pkg.sv
// Shared APB definitions: bus widths, slave FSM state encoding and default parameters.
package apb_pkg;

  localparam int unsigned ADDR_W          = 9;
  localparam int unsigned DATA_W          = 8;
  localparam int unsigned CNT_W           = 4;
  localparam int unsigned DEF_MEM_DEPTH   = 64;
  localparam int unsigned DEF_WAIT_CYCLES = 2;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } slave_state_e;

endpackage

// File: rtl/apb_slave_regfile.sv
// Byte-wide storage with a synchronous write port and a registered read port.
// Contents are never reset; only the read register clears.
module apb_slave_regfile
  import apb_pkg::*;
#(
  parameter int unsigned MEM_DEPTH = DEF_MEM_DEPTH
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [7:0]        addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int unsigned IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  logic [DATA_W-1:0] mem_q [MEM_DEPTH];
  logic [DATA_W-1:0] rdata_q;
  logic [IDX_W-1:0]  idx;

  // Callers only enable a port for in-range addresses, so truncation is safe.
  assign idx = addr_i[IDX_W-1:0];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[idx] <= wdata_i;
    end
  end

  // Read data is held only for the cycle after a read strobe, zero otherwise.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[idx];
    end else begin
      rdata_q <= '0;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/apb_slave_mem.sv
// APB slave fronting a small byte memory, with a programmable number of wait states
// inserted before the single-cycle PREADY response.
module apb_slave_mem
  import apb_pkg::*;
#(
  parameter int unsigned MEM_DEPTH   = DEF_MEM_DEPTH,
  parameter int unsigned WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic [DATA_W-1:0] PWDATA,
  output logic [DATA_W-1:0] PRDATA,
  output logic              PREADY,
  output logic              PSLVERR
);

  slave_state_e      state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [7:0]        addr_q, addr_d;
  logic              wr_q, wr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              pready_q, pslverr_q;
  logic              fire;
  logic              err;
  logic              mem_we, mem_re;
  logic              unused_paddr_msb;

  // The master decodes the top address bit before selecting us.
  assign unused_paddr_msb = PADDR[ADDR_W-1];

  assign err = (32'(addr_q) >= MEM_DEPTH);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wr_d    = wr_q;
    wdata_d = wdata_q;
    fire    = 1'b0;
    case (state_q)
      StIdle: begin
        if (PSEL && !PENABLE) begin
          state_d = StWait;
          addr_d  = PADDR[7:0];
          wr_d    = PWRITE;
          wdata_d = PWDATA;
          cnt_d   = CNT_W'(WAIT_CYCLES);
        end
      end
      StWait: begin
        if (!PSEL) begin
          state_d = StIdle;
        end else if (!PENABLE) begin
          // A fresh setup phase restarts the transfer from scratch.
          addr_d  = PADDR[7:0];
          wr_d    = PWRITE;
          wdata_d = PWDATA;
          cnt_d   = CNT_W'(WAIT_CYCLES);
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = StResp;
          fire    = 1'b1;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign mem_we = fire && wr_q && !err && !PRESET;
  assign mem_re = fire && !wr_q && !err && !PRESET;

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      addr_q    <= '0;
      wr_q      <= 1'b0;
      wdata_q   <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wr_q      <= wr_d;
      wdata_q   <= wdata_d;
      pready_q  <= fire;
      pslverr_q <= fire && err;
    end
  end

  apb_slave_regfile #(
    .MEM_DEPTH(MEM_DEPTH)
  ) u_regfile (
    .clk_i  (PCLK),
    .rst_i  (PRESET),
    .we_i   (mem_we),
    .re_i   (mem_re),
    .addr_i (addr_q),
    .wdata_i(wdata_q),
    .rdata_o(PRDATA)
  );

  assign PREADY  = pready_q;
  assign PSLVERR = pslverr_q;

endmodule

// File: doc/apb_slave_mem.md
APB_SLAVE_MEM -- requirements
Module: apb_slave_mem

Interface
REQ-001 Parameter: MEM_DEPTH, default 64, number of 8-bit storage locations (1..256).
REQ-002 Parameter: WAIT_CYCLES, default 2, number of extra access-phase cycles inserted before PREADY (0..15).
REQ-003 Port: PCLK  input  1  sole clock, all state updates on rising edge.
REQ-004 Port: PRESET  input  1  reset; synchronous, active-high.
REQ-005 Port: PSEL  input  1  slave select from the APB master.
REQ-006 Port: PENABLE  input  1  access-phase indicator from the master.
REQ-007 Port: PWRITE  input  1  1 = write, 0 = read.
REQ-008 Port: PADDR  input  9  transfer address; bits [7:0] index storage, bit 8 is ignored because the master decodes it.
REQ-009 Port: PWDATA  input  8  write data.
REQ-010 Port: PRDATA  output  8  read data, registered.
REQ-011 Port: PREADY  output  1  transfer-complete strobe, registered.
REQ-012 Port: PSLVERR  output  1  transfer error, registered, meaningful only while PREADY=1.

Function
REQ-013 FSM states: IDLE, WAIT, RESP.
- IDLE -> WAIT: on an edge with PSEL=1 and PENABLE=0 (setup sampled).
- IDLE otherwise holds.
REQ-014 On the IDLE->WAIT edge:
- latch addr=PADDR[7:0], wr=PWRITE, wdata=PWDATA;
- load wait counter with WAIT_CYCLES.
REQ-015 In WAIT, on an edge with PSEL=1 and PENABLE=1:
- counter != 0: decrement the counter and stay in WAIT;
- counter == 0: go to RESP.
REQ-016 In WAIT, on an edge with PSEL=0: abort, return to IDLE, no storage write.
REQ-017 In WAIT, on an edge with PSEL=1 and PENABLE=0: treat as a new setup; re-latch per REQ-014 and stay in WAIT.
REQ-018 In RESP:
- PREADY=1 for exactly one cycle;
- the next edge returns to IDLE unconditionally.
REQ-019 Latency: the setup cycle is followed by WAIT_CYCLES+2 access cycles, and PREADY is high in the last one.
- WAIT_CYCLES=0 gives setup T0, access T1 (PREADY=0), access T2 (PREADY=1).
REQ-020 Error: latched addr >= MEM_DEPTH gives PSLVERR=1 in RESP; no storage write, PRDATA=0.
REQ-021 Write: on the WAIT->RESP edge with wr=1 and no error, mem[addr] <= wdata.
- A write is visible to a read in the immediately following transfer.
REQ-022 Read: on the WAIT->RESP edge with wr=0 and no error, PRDATA <= mem[addr].
REQ-023 PRDATA=0 in every cycle except RESP of an error-free read.
REQ-024 PSLVERR=0 in every cycle except RESP.
REQ-025 Back-to-back transfers: a setup presented in the cycle after RESP is accepted from IDLE per REQ-013, with no dead cycle.
REQ-026 The counter never wraps; it saturates at 0.

Reset
REQ-027 While PRESET=1 at an edge:
- state=IDLE, counter=0;
- PREADY=0, PSLVERR=0, PRDATA=0.
REQ-028 Reset mid-transfer (WAIT or RESP) discards the transfer with no storage write.
REQ-029 Storage contents are not reset and are retained across reset.

Structure
REQ-030 Shared package apb_pkg holds:
- ADDR_W=9, DATA_W=8;
- the slave state enum (IDLE/WAIT/RESP);
- the MEM_DEPTH/WAIT_CYCLES defaults.
REQ-031 Storage is a sub-module apb_slave_regfile:
- synchronous write port, registered read port, parameterised by MEM_DEPTH;
- the FSM and wait counter stay in apb_slave_mem.

Verification
REQ-032 Reset then write: WAIT_CYCLES=2, write 0xA5 to addr 0x005 -> PREADY high exactly in the 4th access cycle, PSLVERR=0, PRDATA=0.
REQ-033 Read-back: read addr 0x005 right after REQ-032 -> PRDATA=0xA5 with PREADY=1, and PRDATA=0 in the following cycle.
REQ-034 Out-of-range: MEM_DEPTH=64, write 0x3C to addr 0x040 -> PSLVERR=1 with PREADY; a later read of addr 0x000 returns its previous value unchanged.
REQ-035 Zero wait: WAIT_CYCLES=0, back-to-back write 0x11 to 0x001 then read 0x001 -> PREADY in the 2nd access cycle of each transfer, read returns 0x11, no idle cycle between transfers.
REQ-036 Abort: drop PSEL during WAIT of a write of 0x77 to 0x002 -> FSM back in IDLE and PREADY never asserted; a later read of 0x002 returns its prior value.
REQ-037 Reset mid-transfer: assert PRESET in WAIT of a write of 0x99 to 0x003 -> all outputs 0 on the next cycle and mem[3] unchanged.
